// File: rtl/mips_mem_arbiter.sv
// Two-to-one arbiter: MIPS32 split instruction/data ports onto one unified word-addressed memory port.
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data grants.
//
// state | meaning
// IDLE  | no transaction in flight, arbitrate pending requests
// DATA  | data transaction held on the unified port, waiting for Mem_Ready
// INST  | fetch transaction held on the unified port, waiting for Mem_Ready
// ACK_D | DataMem_Ready pulse cycle, no grant
// ACK_I | InstMem_Ready pulse cycle, no grant
module mips_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        DataMem_Read,
    input  logic [3:0]  DataMem_Write,
    input  logic [29:0] DataMem_Address,
    input  logic [31:0] DataMem_Out,
    output logic [31:0] DataMem_In,
    output logic        DataMem_Ready,
    input  logic        InstMem_Read,
    input  logic [29:0] InstMem_Address,
    output logic [31:0] InstMem_In,
    output logic        InstMem_Ready,
    output logic        Mem_Read,
    output logic [3:0]  Mem_Write,
    output logic [29:0] Mem_Address,
    output logic [31:0] Mem_WriteData,
    input  logic [31:0] Mem_ReadData,
    input  logic        Mem_Ready
);

    localparam int CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        INST,
        ACK_D,
        ACK_I
    } stateT;

    stateT           state;
    stateT           stateNext;
    logic [CntW-1:0] starveCnt;
    logic            dataPending;
    logic            starveHit;
    logic            grantInst;
    logic            grantData;

    assign dataPending = DataMem_Read | (|DataMem_Write);
    assign starveHit   = (STARVE_LIMIT != 0) && (starveCnt == CntMax);
    assign grantInst   = (state == IDLE) && InstMem_Read && (!dataPending || starveHit);
    assign grantData   = (state == IDLE) && dataPending && !grantInst;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (grantInst)      stateNext = INST;
                else if (grantData) stateNext = DATA;
            end
            DATA:    if (Mem_Ready) stateNext = ACK_D;
            INST:    if (Mem_Ready) stateNext = ACK_I;
            ACK_D,
            ACK_I:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Unified-port request registers and CPU-side response registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Mem_Read      <= 1'b0;
            Mem_Write     <= 4'b0;
            Mem_Address   <= 30'b0;
            Mem_WriteData <= 32'b0;
            DataMem_In    <= 32'b0;
            DataMem_Ready <= 1'b0;
            InstMem_In    <= 32'b0;
            InstMem_Ready <= 1'b0;
        end else begin
            DataMem_Ready <= 1'b0;
            InstMem_Ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantInst) begin
                        Mem_Read    <= 1'b1;
                        Mem_Write   <= 4'b0;
                        Mem_Address <= InstMem_Address;
                    end else if (grantData) begin
                        Mem_Address <= DataMem_Address;
                        if (DataMem_Read) begin
                            Mem_Read  <= 1'b1;
                            Mem_Write <= 4'b0;
                        end else begin
                            Mem_Read      <= 1'b0;
                            Mem_Write     <= DataMem_Write;
                            Mem_WriteData <= DataMem_Out;
                        end
                    end
                end
                DATA: begin
                    if (Mem_Ready) begin
                        // Mem_Read still reflects the held request here: only reads update DataMem_In.
                        if (Mem_Read) DataMem_In <= Mem_ReadData;
                        Mem_Read      <= 1'b0;
                        Mem_Write     <= 4'b0;
                        DataMem_Ready <= 1'b1;
                    end
                end
                INST: begin
                    if (Mem_Ready) begin
                        InstMem_In    <= Mem_ReadData;
                        Mem_Read      <= 1'b0;
                        Mem_Write     <= 4'b0;
                        InstMem_Ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starveCnt <= '0;
        end else if (grantInst) begin
            starveCnt <= '0;
        end else if (grantData) begin
            if (!InstMem_Read)
                starveCnt <= '0;
            else if ((STARVE_LIMIT != 0) && (starveCnt != CntMax))
                starveCnt <= starveCnt + CntW'(1);
        end
    end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Two-to-one memory arbiter between the MIPS32 core's split instruction/data memory ports and a single unified word-addressed memory port (BFM or on-chip RAM). It registers each request, forwards it as one held transaction to the unified port, and returns a one-cycle Ready pulse plus registered read data on the originating CPU port. Data accesses take priority. A bounded starvation counter guarantees instruction fetch progress.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits; 0 = strict data priority, no limit.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- DataMem_Read  in  1  CPU data read request, held until DataMem_Ready.
- DataMem_Write  in  4  CPU byte write enables, held until DataMem_Ready.
- DataMem_Address  in  30  CPU data word address.
- DataMem_Out  in  32  CPU store data.
- DataMem_In  out  32  read data to CPU, registered.
- DataMem_Ready  out  1  one-cycle completion pulse, data port.
- InstMem_Read  in  1  CPU fetch request, held until InstMem_Ready.
- InstMem_Address  in  30  fetch word address.
- InstMem_In  out  32  fetched instruction, registered.
- InstMem_Ready  out  1  one-cycle completion pulse, fetch port.
- Mem_Read  out  1  unified read request, held until Mem_Ready.
- Mem_Write  out  4  unified byte enables, held until Mem_Ready.
- Mem_Address  out  30  unified word address.
- Mem_WriteData  out  32  unified store data.
- Mem_ReadData  in  32  unified read data, valid with Mem_Ready.
- Mem_Ready  in  1  one-cycle completion pulse from memory (reads and writes).

## Operation
- States: IDLE, DATA, INST, ACK_D, ACK_I.
- IDLE: data pending = DataMem_Read | (|DataMem_Write); inst pending = InstMem_Read.
  - Grant INST if inst pending and (no data pending or STARVE_LIMIT≠0 and starve_cnt == STARVE_LIMIT); else grant DATA if data pending; else stay.
  - DATA grant: latch address; if DataMem_Read, Mem_Read←1, Mem_Write←0 (read wins, write strobes ignored); else Mem_Write←DataMem_Write, Mem_WriteData←DataMem_Out.
  - INST grant: Mem_Read←1, Mem_Address←InstMem_Address, Mem_Write←0.
- DATA/INST: hold Mem_* stable; CPU inputs ignored. On Mem_Ready: clear Mem_Read/Mem_Write; DATA read→DataMem_In←Mem_ReadData; INST→InstMem_In←Mem_ReadData; go ACK_D/ACK_I with matching Ready←1.
- ACK_D/ACK_I: Ready high this cycle only; next edge Ready←0, IDLE. No grant in ACK (prevents re-grant of request CPU is about to drop).
- DataMem_In unchanged on write completion; InstMem_In/DataMem_In hold last value otherwise.
- starve_cnt, width clog2(STARVE_LIMIT+1), saturating: +1 on DATA grant with InstMem_Read high; cleared on INST grant or DATA grant with InstMem_Read low.
- reset_n low (any time, incl. mid-transaction): state IDLE, all outputs 0, starve_cnt 0; in-flight transaction abandoned; memory resets together.

## Timing
- Reset values: DataMem_In, InstMem_In, Mem_Address, Mem_WriteData = 0; all Ready/Read/Write = 0.
- All outputs registered; no combinational input→output path.
- Request seen in IDLE cycle n → Mem_* asserted cycle n+1 → Mem_Ready cycle m (≥ n+1) → CPU Ready cycle m+1 → IDLE m+2.
- Memory with registered 1-cycle response (Mem_Ready at n+2): CPU Ready at n+3; back-to-back transactions every 4 cycles.
- Mem_Ready outside DATA/INST ignored.
- Exactly one Ready pulse per granted request; never both ports Ready in same cycle.

## Test plan
- Single fetch: InstMem_Read=1, addr 0x10, memory returns 0x2408_0005 one cycle after request -> InstMem_Ready pulse 3 cycles after request, InstMem_In=0x2408_0005, Mem_Read dropped on Mem_Ready edge.
- Simultaneous: DataMem_Read addr 0x40 and InstMem_Read addr 0x00 same cycle -> data served first, fetch granted in IDLE after ACK_D; Ready pulses ordered data then inst.
- Byte write: DataMem_Write=4'b0011, DataMem_Out=0xAABB_CCDD, addr 0x20 -> Mem_Write=4'b0011, Mem_WriteData=0xAABB_CCDD held to Mem_Ready; DataMem_Ready pulse; DataMem_In unchanged.
- Starvation, STARVE_LIMIT=4: data request held continuously plus fetch pending -> 4 data grants, then fetch granted; counter cleared; with STARVE_LIMIT=0 fetch never granted while data pending.
- Read+write together: DataMem_Read=1, DataMem_Write=4'hF -> Mem_Read=1, Mem_Write=0.
- Reset mid-transaction: reset_n low while in DATA with Mem_Read=1 -> all outputs 0 immediately (async); after release, pending fetch completes normally, no stray DataMem_Ready.
